// File: rtl/imm_extend_pipe.sv
// Immediate extender with one-cycle valid/ready pipeline and MOVZ/MOVK accumulator.
// Optional transfer counter enabled by defining IMM_EXTEND_PIPE_XFER_COUNT_EN.
module imm_extend_pipe #(
  parameter int DATA_W   = 64,
  parameter int BR_SCALE = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [25:0]       Imm26,
  input  logic [2:0]        Ctrl,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] BusImm,
  output logic              Err,
  output logic [15:0]       XferCount
);

  typedef enum logic [2:0] {
    FMT_I    = 3'b000,
    FMT_D    = 3'b001,
    FMT_B    = 3'b010,
    FMT_CB   = 3'b011,
    FMT_MOVZ = 3'b100,
    FMT_MOVK = 3'b101
  } fmt_e;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_bus;
  logic              r_err;
  logic [DATA_W-1:0] r_acc;

  logic              w_accept;
  logic [1:0]        w_hw;
  logic [5:0]        w_shift;
  logic              w_lane_ok;
  logic [DATA_W-1:0] w_movz;
  logic [DATA_W-1:0] w_movk;
  logic [DATA_W-1:0] w_result;
  logic              w_err;
  logic              w_acc_we;

  assign InReady  = ~r_out_valid | OutReady;
  assign w_accept = InValid & InReady;

  assign w_hw      = Imm26[22:21];
  assign w_shift   = {w_hw, 4'b0000};
  // A 32-bit bus only has lanes 0 and 1.
  assign w_lane_ok = (DATA_W == 64) || !w_hw[1];
  assign w_movz    = DATA_W'(Imm26[20:5]) << w_shift;
  assign w_movk    = (r_acc & ~(DATA_W'(16'hFFFF) << w_shift)) | w_movz;

  always_comb begin
    w_result = '0;
    w_err    = 1'b0;
    w_acc_we = 1'b0;
    case (Ctrl)
      FMT_I: w_result = DATA_W'($signed(Imm26[21:10]));
      FMT_D: w_result = DATA_W'($signed(Imm26[20:12]));
      FMT_B: begin
        w_result = DATA_W'($signed(Imm26[25:0]));
        if (BR_SCALE != 0) w_result = w_result << 2;
      end
      FMT_CB: begin
        w_result = DATA_W'($signed(Imm26[23:5]));
        if (BR_SCALE != 0) w_result = w_result << 2;
      end
      FMT_MOVZ: begin
        if (w_lane_ok) begin
          w_result = w_movz;
          w_acc_we = 1'b1;
        end else begin
          w_err = 1'b1;
        end
      end
      FMT_MOVK: begin
        if (w_lane_ok) begin
          w_result = w_movk;
          w_acc_we = 1'b1;
        end else begin
          w_err = 1'b1;
        end
      end
      default: w_err = 1'b1;
    endcase
  end

  // The output register holds its value while stalled; a transfer without a
  // new accept only drops the valid flag.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_out_valid <= 1'b0;
      r_bus       <= '0;
      r_err       <= 1'b0;
      r_acc       <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_bus       <= w_result;
      r_err       <= w_err;
      if (w_acc_we) r_acc <= w_result;
    end else if (OutReady) begin
      r_out_valid <= 1'b0;
    end
  end

  assign OutValid = r_out_valid;
  assign BusImm   = r_bus;
  assign Err      = r_err;

`ifdef IMM_EXTEND_PIPE_XFER_COUNT_EN
  logic [15:0] r_xfer_cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_xfer_cnt <= '0;
    end else if (r_out_valid && OutReady && (r_xfer_cnt != 16'hFFFF)) begin
      r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end
  end

  assign XferCount = r_xfer_cnt;
`else
  assign XferCount = 16'd0;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench: one 64-bit/BR_SCALE=1 and one 32-bit/BR_SCALE=0 instance
// share the same stimulus; a monitor pops expected results on each transfer.
module tb_imm_extend_pipe;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        InValid;
  logic        OutReady;
  logic [25:0] Imm26;
  logic [2:0]  Ctrl;

  logic        a_in_ready, a_ov, a_err;
  logic [63:0] a_bus;
  logic [15:0] a_xfer;
  logic        b_in_ready, b_ov, b_err;
  logic [31:0] b_bus;
  logic [15:0] b_xfer;

  imm_extend_pipe #(.DATA_W(64), .BR_SCALE(1)) u_dut64 (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(a_in_ready),
    .Imm26(Imm26), .Ctrl(Ctrl), .OutValid(a_ov), .OutReady(OutReady),
    .BusImm(a_bus), .Err(a_err), .XferCount(a_xfer)
  );

  imm_extend_pipe #(.DATA_W(32), .BR_SCALE(0)) u_dut32 (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(b_in_ready),
    .Imm26(Imm26), .Ctrl(Ctrl), .OutValid(b_ov), .OutReady(OutReady),
    .BusImm(b_bus), .Err(b_err), .XferCount(b_xfer)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [63:0] e64;
    logic        er64;
    logic [31:0] e32;
    logic        er32;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  always @(negedge Clk) begin
    if (mon_en && !Reset && a_ov && OutReady) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %h want none", a_bus);
      end else begin
        mon_e = sb.pop_front();
        chk("bus64", a_bus, mon_e.e64);
        chk("err64", {63'b0, a_err}, {63'b0, mon_e.er64});
        chk("bus32", {32'b0, b_bus}, {32'b0, mon_e.e32});
        chk("err32", {63'b0, b_err}, {63'b0, mon_e.er32});
        chk("ov32", {63'b0, b_ov}, 64'd1);
        $display("xfer bus64=%h err64=%b bus32=%h err32=%b", a_bus, a_err, b_bus, b_err);
      end
    end
  end

  task automatic send(input logic [2:0] c, input logic [25:0] imm,
                      input logic [63:0] e64, input logic er64,
                      input logic [31:0] e32, input logic er32);
    exp_t e;
    bit   got;
    int   n;
    got = 1'b0;
    n   = 0;
    e.e64 = e64; e.er64 = er64; e.e32 = e32; e.er32 = er32;
    Ctrl    = c;
    Imm26   = imm;
    InValid = 1'b1;
    sb.push_back(e);
    while (!got && n < 20) begin
      @(negedge Clk);
      got = a_in_ready;
      @(posedge Clk);
      #1;
      n++;
    end
    InValid = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no accept want accept");
    end
  endtask

  initial begin
    int n;
    Reset    = 1'b1;
    InValid  = 1'b0;
    OutReady = 1'b1;
    Imm26    = '0;
    Ctrl     = '0;
    #12;
    chk("rst_ov", {63'b0, a_ov}, 64'd0);
    chk("rst_bus", a_bus, 64'd0);
    chk("rst_err", {63'b0, a_err}, 64'd0);
    chk("rst_xfer", {48'b0, a_xfer}, 64'd0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    chk("ready_after_rst", {63'b0, a_in_ready}, 64'd1);
    @(posedge Clk); #1;

    // Format vectors, back-to-back with OutReady held high.
    send(3'b000, 26'h0200000, 64'hFFFF_FFFF_FFFF_F800, 1'b0, 32'hFFFF_F800, 1'b0);
    send(3'b000, 26'h01FFC00, 64'h0000_0000_0000_07FF, 1'b0, 32'h0000_07FF, 1'b0);
    send(3'b001, 26'h0100000, 64'hFFFF_FFFF_FFFF_FF00, 1'b0, 32'hFFFF_FF00, 1'b0);
    send(3'b001, 26'h00FF000, 64'h0000_0000_0000_00FF, 1'b0, 32'h0000_00FF, 1'b0);
    send(3'b010, 26'h3FFFFFF, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'hFFFF_FFFF, 1'b0);
    send(3'b010, 26'h1000000, 64'h0000_0000_0400_0000, 1'b0, 32'h0100_0000, 1'b0);
    send(3'b011, 26'h0800000, 64'hFFFF_FFFF_FFF0_0000, 1'b0, 32'hFFFC_0000, 1'b0);
    // MOV chain; the reserved op in the middle must not touch Acc.
    send(3'b100, 26'h0024680, 64'h0000_0000_0000_1234, 1'b0, 32'h0000_1234, 1'b0);
    send(3'b101, 26'h07579A0, 64'hABCD_0000_0000_1234, 1'b0, 32'h0000_0000, 1'b1);
    send(3'b110, 26'h3FFFFFF, 64'h0, 1'b1, 32'h0, 1'b1);
    send(3'b101, 26'h02ACF00, 64'hABCD_0000_5678_1234, 1'b0, 32'h5678_1234, 1'b0);
    send(3'b111, 26'h3FFFFFF, 64'h0, 1'b1, 32'h0, 1'b1);
    send(3'b100, 26'h0401FE0, 64'h0000_00FF_0000_0000, 1'b0, 32'h0000_0000, 1'b1);
    send(3'b101, 26'h0000020, 64'h0000_00FF_0000_0001, 1'b0, 32'h5678_0001, 1'b0);

    // Stall: result held for 3 cycles with a pending request.
    @(posedge Clk); #1;
    OutReady = 1'b0;
    send(3'b000, 26'h01FFC00, 64'h7FF, 1'b0, 32'h7FF, 1'b0);
    Ctrl = 3'b010; Imm26 = 26'h1000000; InValid = 1'b1;
    begin
      exp_t e;
      e.e64 = 64'h0400_0000; e.er64 = 1'b0; e.e32 = 32'h0100_0000; e.er32 = 1'b0;
      sb.push_back(e);
    end
    repeat (3) begin
      @(negedge Clk);
      chk("stall_ready", {63'b0, a_in_ready}, 64'd0);
      chk("stall_bus", a_bus, 64'h7FF);
      chk("stall_ov", {63'b0, a_ov}, 64'd1);
      @(posedge Clk); #1;
    end
    OutReady = 1'b1;
    @(negedge Clk);
    chk("release_ready", {63'b0, a_in_ready}, 64'd1);
    @(posedge Clk); #1;
    InValid = 1'b0;
    @(negedge Clk);
    chk("nobubble_ov", {63'b0, a_ov}, 64'd1);
    @(posedge Clk); #1;

    // Reset mid-stream drops the held result and clears Acc.
    OutReady = 1'b0;
    send(3'b100, 26'h02AAAA0, 64'h5555_0000, 1'b0, 32'h5555_0000, 1'b0);
    #3;
    Reset = 1'b1;
    #1;
    chk("midrst_ov", {63'b0, a_ov}, 64'd0);
    chk("midrst_bus", a_bus, 64'd0);
    chk("midrst_ov32", {63'b0, b_ov}, 64'd0);
    sb.delete();
    @(posedge Clk); #1;
    Reset    = 1'b0;
    OutReady = 1'b1;
    @(negedge Clk);
    chk("post_rst_ready", {63'b0, a_in_ready}, 64'd1);
    @(posedge Clk); #1;
    send(3'b101, 26'h0001540, 64'h0000_0000_0000_00AA, 1'b0, 32'h0000_00AA, 1'b0);

    n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(posedge Clk);
      n++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    @(posedge Clk); #1;

`ifdef IMM_EXTEND_PIPE_XFER_COUNT_EN
    mon_en  = 1'b0;
    Ctrl    = 3'b000;
    Imm26   = '0;
    InValid = 1'b1;
    repeat (70000) @(posedge Clk);
    #1;
    InValid = 1'b0;
    @(negedge Clk);
    chk("xfer_sat", {48'b0, a_xfer}, 64'h0000_0000_0000_FFFF);
`else
    chk("xfer_tied64", {48'b0, a_xfer}, 64'd0);
    chk("xfer_tied32", {48'b0, b_xfer}, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, giving the immediate bus width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter BR_SCALE, default 0; when 1, B and CB offsets are shifted left by 2 after extension.
REQ-003 Port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port InValid, input, 1 bit: Imm26/Ctrl hold a valid request.
REQ-006 Port InReady, output, 1 bit: the block accepts the request this cycle.
REQ-007 Port Imm26, input, 26 bits: raw instruction immediate field.
REQ-008 Port Ctrl, input, 3 bits: format select; 000 I, 001 D, 010 B, 011 CB, 100 MOVZ, 101 MOVK, 110/111 reserved.
REQ-009 Port OutValid, output, 1 bit: BusImm/Err hold a result.
REQ-010 Port OutReady, input, 1 bit: the consumer takes the result this cycle.
REQ-011 Port BusImm, output, DATA_W bits: extended immediate.
REQ-012 Port Err, output, 1 bit: the current result is from a reserved Ctrl value or an illegal shift.
REQ-013 Port XferCount, output, 16 bits: count of completed output transfers (see Configuration).

Function
REQ-014 Accept SHALL equal InValid and InReady; InReady SHALL be the combinational value (not OutValid) or OutReady.
REQ-015 Latency SHALL be one cycle: an accepted request appears on BusImm with OutValid=1 on the next rising edge.
REQ-016 While OutValid=1 and OutReady=0, BusImm, Err and OutValid SHALL hold unchanged.
REQ-017 A transfer with OutReady=1 and no accept SHALL clear OutValid on the next edge; a transfer plus accept in the same cycle SHALL load the new result with OutValid staying 1, with no bubble.
REQ-018 I: sign-extend Imm26[21:10] (12 bits) to DATA_W.
REQ-019 D: sign-extend Imm26[20:12] (9 bits) to DATA_W.
REQ-020 B: sign-extend Imm26[25:0] (26 bits) to DATA_W, then shift left 2 if BR_SCALE=1.
REQ-021 CB: sign-extend Imm26[23:5] (19 bits) to DATA_W, then shift left 2 if BR_SCALE=1.
REQ-022 MOVZ: with hw=Imm26[22:21], place Imm26[20:5] at bits [16*hw+15:16*hw] and zero all other bits.
REQ-023 The block SHALL hold an internal DATA_W-bit accumulator Acc; an accepted MOVZ SHALL load Acc with the MOVZ result.
REQ-024 MOVK: replace lane hw of Acc with Imm26[20:5] and keep all other lanes; the result SHALL be written to both BusImm and Acc.
REQ-025 Back-to-back MOVK requests SHALL chain: each SHALL use the Acc value updated by the previous accepted request.
REQ-026 Non-MOV formats SHALL leave Acc unchanged.
REQ-027 When DATA_W=32 and a MOVZ/MOVK request has hw>=2, the result SHALL be BusImm=0 with Err=1, and Acc SHALL stay unchanged.
REQ-028 Reserved Ctrl values SHALL produce BusImm=0 with Err=1; otherwise Err=0.
REQ-029 Arithmetic SHALL wrap modulo 2^DATA_W; the BR_SCALE shift SHALL discard the top 2 bits.

Reset
REQ-030 Reset=1 SHALL force, asynchronously: OutValid=0, BusImm=0, Err=0, Acc=0, XferCount=0.
REQ-031 A request in flight during reset SHALL be dropped; InReady SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-032 Macro IMM_EXTEND_PIPE_XFER_COUNT_EN, when defined, SHALL enable a 16-bit counter that increments on each OutValid and OutReady cycle and saturates at 16'hFFFF; it is driven on XferCount.
REQ-033 Without IMM_EXTEND_PIPE_XFER_COUNT_EN, XferCount SHALL be tied to 0 and no counter logic is built.

Verification
REQ-034 I request with Imm26[21:10]=12'h800, DATA_W=64, OutReady=1 -> next cycle OutValid=1, BusImm=64'hFFFF_FFFF_FFFF_F800, Err=0.
REQ-035 B request with Imm26=26'h3FFFFFF, BR_SCALE=1 -> BusImm=64'hFFFF_FFFF_FFFF_FFFC.
REQ-036 MOVZ with hw=0 and imm 16'h1234, then MOVK with hw=3 and imm 16'hABCD, back-to-back -> results 64'h1234, then 64'hABCD_0000_0000_1234.
REQ-037 OutReady=0 for 3 cycles with a result held and InValid=1 -> InReady=0, BusImm stable; on OutReady=1 the next result loads on the following edge with no bubble.
REQ-038 Ctrl=110 -> BusImm=0, Err=1; with DATA_W=32, MOVZ with hw=2 -> BusImm=0, Err=1, Acc unchanged.
REQ-039 Reset asserted mid-stream -> OutValid=0 and Acc=0 immediately; with the macro defined, 70000 transfers -> XferCount=16'hFFFF.
